// File: rtl/imem_fetch.sv
// Instruction store and single-entry fetch stage: a program-load port fills the
// array, and the word for PC is registered with a tag so BUSYWAIT can flag a stale word.
module imem_fetch #(
  parameter int          DEPTH    = 128,
  parameter int          AW       = 7,
  parameter int          IW       = 19,
  parameter logic [18:0] OOR_WORD = 19'h7FFFF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   PC,
  output logic [IW-1:0] INSTRUCTION,
  output logic          BUSYWAIT,
  input  logic          LOAD_EN,
  input  logic [AW-1:0] LOAD_ADDR,
  input  logic [IW-1:0] LOAD_DATA,
  output logic          PC_ERR,
  output logic [15:0]   FETCH_CNT
);

  typedef enum logic [1:0] {S_LOAD, S_INVALID, S_VALID} state_t;

  state_t        state_q;
  logic [31:0]   tag_q;
  logic [IW-1:0] instr_q;
  logic          err_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [IW-1:0] mem_q [DEPTH];

  logic fetch, in_range;

  // INVALID always fetches; VALID only when the held word belongs to another PC.
  assign fetch    = !LOAD_EN && ((state_q == S_INVALID) ||
                                 ((state_q == S_VALID) && (PC != tag_q)));
  assign in_range = (PC[31:AW] == '0);
  assign cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Storage is deliberately not reset so a program survives RESET.
  always_ff @(posedge CLK) begin
    if (!RESET && LOAD_EN)
      mem_q[LOAD_ADDR] <= LOAD_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_INVALID;
      tag_q   <= 32'hFFFF_FFFF;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else if (LOAD_EN) begin
      state_q <= S_LOAD;
    end else if (state_q == S_LOAD) begin
      state_q <= S_INVALID;
    end else if (fetch) begin
      state_q <= S_VALID;
      tag_q   <= PC;
      cnt_q   <= cnt_d;
      if (in_range) begin
        instr_q <= mem_q[PC[AW-1:0]];
      end else begin
        instr_q <= OOR_WORD;
        err_q   <= 1'b1;
      end
    end
  end

  assign INSTRUCTION = instr_q;
  assign PC_ERR      = err_q;
  assign FETCH_CNT   = cnt_q;
  assign BUSYWAIT    = (state_q != S_VALID) || (PC != tag_q);

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: directed scenarios plus random traffic, checked every
// cycle against an abstract model of the fetch stage.
module tb_imem_fetch;

  logic        CLK = 1'b0;
  logic        RESET, LOAD_EN;
  logic [31:0] PC;
  logic [6:0]  LOAD_ADDR;
  logic [18:0] LOAD_DATA;
  logic [18:0] INSTRUCTION;
  logic        BUSYWAIT, PC_ERR;
  logic [15:0] FETCH_CNT;

  imem_fetch dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT(BUSYWAIT), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR),
    .LOAD_DATA(LOAD_DATA), .PC_ERR(PC_ERR), .FETCH_CNT(FETCH_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Abstract model: a memory array, a "word is good for tag" flag and a
  // one-cycle penalty after any load burst.
  logic [18:0] m_mem [128];
  bit          m_known [128];
  bit          m_inload = 0, m_valid = 0, m_ik = 0, m_err = 0, m_rst_seen = 0;
  logic [31:0] m_tag;
  logic [18:0] m_instr;
  int          m_cnt;

  always @(posedge CLK) begin
    if (RESET) begin
      m_inload = 0; m_valid = 0; m_tag = 32'hFFFF_FFFF;
      m_instr = 0; m_ik = 1; m_err = 0; m_cnt = 0; m_rst_seen = 1;
    end else if (LOAD_EN) begin
      m_mem[LOAD_ADDR] = LOAD_DATA;
      m_known[LOAD_ADDR] = 1;
      m_inload = 1; m_valid = 0;
    end else if (m_inload) begin
      m_inload = 0;
    end else if (!m_valid || PC != m_tag) begin
      m_tag = PC;
      m_valid = 1;
      if (PC < 128) begin
        m_instr = m_mem[PC[6:0]];
        m_ik = m_known[PC[6:0]];
      end else begin
        m_instr = 19'h7FFFF;
        m_ik = 1;
        m_err = 1;
      end
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (m_rst_seen) begin
      cmp("busywait", 32'(BUSYWAIT), 32'(!m_valid || (PC != m_tag)));
      cmp("pc_err", 32'(PC_ERR), 32'(m_err));
      cmp("fetch_cnt", 32'(FETCH_CNT), 32'(m_cnt));
      if (m_ik) cmp("instruction", 32'(INSTRUCTION), 32'(m_instr));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [18:0] prog [128];

  initial begin
    RESET = 1; LOAD_EN = 0; PC = 0; LOAD_ADDR = 0; LOAD_DATA = 0;
    tick();
    // Fill the whole store so every later read is known.
    RESET = 0; LOAD_EN = 1;
    for (int i = 0; i < 128; i++) begin
      prog[i] = (i == 0) ? 19'b1000000010001000001 : 19'($urandom);
      LOAD_ADDR = 7'(i); LOAD_DATA = prog[i];
      tick();
    end
    LOAD_EN = 0;
    RESET = 1;
    tick(); tick();
    cmp("rst_instr", 32'(INSTRUCTION), 32'h0);
    cmp("rst_busy", 32'(BUSYWAIT), 32'h1);
    cmp("rst_err", 32'(PC_ERR), 32'h0);
    cmp("rst_cnt", 32'(FETCH_CNT), 32'h0);
    RESET = 0; PC = 0;
    tick();
    cmp("first_word", 32'(INSTRUCTION), 32'h40441);
    cmp("first_busy", 32'(BUSYWAIT), 32'h0);

    // Load words 0-12 straight out of reset, then step PC through them.
    RESET = 1; LOAD_EN = 1;
    tick();
    RESET = 0;
    for (int i = 0; i < 13; i++) begin
      prog[i] = 19'(32'h1000 + i * 32'h111);
      LOAD_ADDR = 7'(i); LOAD_DATA = prog[i];
      tick();
      cmp("load_busy", 32'(BUSYWAIT), 32'h1);
    end
    LOAD_EN = 0; PC = 0;
    tick();
    cmp("post_load_busy", 32'(BUSYWAIT), 32'h1);
    tick();
    cmp("run_word0", 32'(INSTRUCTION), 32'h1000);
    for (int i = 1; i < 13; i++) begin
      PC = 32'(i);
      #1;
      cmp("run_stall", 32'(BUSYWAIT), 32'h1);
      tick();
      cmp("run_word", 32'(INSTRUCTION), 32'(prog[i]));
      cmp("run_ready", 32'(BUSYWAIT), 32'h0);
    end
    cmp("run_cnt", 32'(FETCH_CNT), 32'd13);

    PC = 5;
    tick();
    cmp("hold_word", 32'(INSTRUCTION), 32'h1555);
    for (int i = 0; i < 10; i++) begin
      tick();
      cmp("hold_busy", 32'(BUSYWAIT), 32'h0);
    end
    cmp("hold_cnt", 32'(FETCH_CNT), 32'd14);

    PC = 128;
    tick();
    cmp("oor128_word", 32'(INSTRUCTION), 32'h7FFFF);
    cmp("oor128_err", 32'(PC_ERR), 32'h1);
    PC = 32'h8000_0000;
    tick();
    cmp("oor_hi_word", 32'(INSTRUCTION), 32'h7FFFF);
    PC = 3;
    tick();
    cmp("back_word", 32'(INSTRUCTION), 32'h1333);
    cmp("err_sticky", 32'(PC_ERR), 32'h1);

    PC = 4;
    tick();
    LOAD_EN = 1; LOAD_ADDR = 4; LOAD_DATA = 19'h12345;
    tick();
    cmp("reload_busy", 32'(BUSYWAIT), 32'h1);
    LOAD_EN = 0;
    tick();
    cmp("reload_invalid", 32'(BUSYWAIT), 32'h1);
    tick();
    cmp("reload_word", 32'(INSTRUCTION), 32'h12345);
    cmp("reload_ready", 32'(BUSYWAIT), 32'h0);

    // Reset landing in the middle of a load keeps the words already written.
    LOAD_EN = 1;
    for (int i = 0; i < 3; i++) begin
      prog[100 + i] = 19'($urandom);
      LOAD_ADDR = 7'(100 + i); LOAD_DATA = prog[100 + i];
      tick();
    end
    RESET = 1; LOAD_DATA = 19'h0;
    tick();
    RESET = 0; LOAD_EN = 0;
    for (int i = 0; i < 3; i++) begin
      PC = 32'(100 + i);
      tick();
      cmp("midload_word", 32'(INSTRUCTION), 32'(prog[100 + i]));
    end
    cmp("midload_err", 32'(PC_ERR), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      RESET = (r < 2);
      LOAD_EN = (r >= 2 && r < 12);
      LOAD_ADDR = 7'($urandom);
      LOAD_DATA = 19'($urandom);
      if ($urandom_range(0, 9) < 3)
        PC = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 140));
      tick();
    end

    RESET = 1; LOAD_EN = 0;
    tick();
    RESET = 0;
    for (int i = 0; i < 65540; i++) begin
      PC = (i % 2 == 1) ? 32'd7 : 32'd8;
      tick();
    end
    cmp("sat_cnt", 32'(FETCH_CNT), 32'hFFFF);
    PC = 9;
    tick(); tick();
    cmp("sat_hold", 32'(FETCH_CNT), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
